// File: rtl/cla_seq_word_adder.sv
// Multi-cycle word adder that reuses one 4-bit carry-lookahead slice, one nibble per cycle.
// Operands arrive over a valid/ready handshake; the result leaves over a second one.

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c[3:0];
    c_out = c[4];
  end
endmodule

module cla_seq_word_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;
  logic             ovf_reg;

  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_c_out;
  logic             accept;
  logic             last_nib;

  // Slice operands come only from registers, never straight from the input ports.
  always_comb begin
    a_shift = a_reg >> {idx, 2'b00};
    b_shift = b_reg >> {idx, 2'b00};
    slice_a = a_shift[3:0];
    slice_b = b_shift[3:0];
  end

  cla4_slice u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_c_out)
  );

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_nib  = (idx == IDX_LAST);
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign ovf       = ovf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[{idx, 2'b00} +: 4] <= slice_sum;
          carry                      <= slice_c_out;
          if (last_nib) begin
            idx       <= '0;
            c_out_reg <= slice_c_out;
            // The top nibble lands in sum_reg this same edge, so take its MSB from the slice.
            ovf_reg   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (slice_sum[3] != a_reg[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_word_adder.sv
// Randomized and directed bench for cla_seq_word_adder, checked against plain integer addition.
`timescale 1ns/1ps
module tb_cla_seq_word_adder;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_seq_word_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic scramble_inputs();
    a    = 16'($urandom);
    b    = 16'($urandom);
    c_in = 1'($urandom);
  endtask

  // One full operation: accept, wait for result, optional backpressure, consume.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input int stall, input bit scramble);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_c, exp_ovf;
    bit               got;
    int               n;
    full    = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
    exp_sum = full[WIDTH-1:0];
    exp_c   = full[WIDTH];
    exp_ovf = (ta[WIDTH-1] == tb[WIDTH-1]) && (exp_sum[WIDTH-1] != ta[WIDTH-1]);

    @(negedge clk);
    check_val("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; a = ta; b = tb; c_in = tc;
    @(posedge clk); #1;
    if (scramble) scramble_inputs();
    else in_valid = 1'b0;

    got = 0; n = 0;
    while (!got && n < 20) begin
      @(posedge clk); n++; #1;
      if (scramble) scramble_inputs();
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) begin
      check_val("result_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    check_val("latency", n, NSLICE);
    check_val("sum", {16'b0, sum}, {16'b0, exp_sum});
    check_val("c_out", {31'b0, c_out}, {31'b0, exp_c});
    check_val("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
    check_val("in_ready_done", {31'b0, in_ready}, 32'd0);

    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (scramble) scramble_inputs();
      @(negedge clk);
      check_val("hold_valid", {31'b0, out_valid}, 32'd1);
      check_val("hold_sum", {16'b0, sum}, {16'b0, exp_sum});
      check_val("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end

    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_val("idle_in_ready", {31'b0, in_ready}, 32'd1);
    check_val("idle_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_sum", {16'b0, sum}, 32'd0);
    check_val("post_rst_c_out", {31'b0, c_out}, 32'd0);
    check_val("post_rst_ovf", {31'b0, ovf}, 32'd0);
    check_val("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_op(16'h0005, 16'h0009, 1'b0, 0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0);
    run_op(16'h7FFF, 16'h0000, 1'b1, 0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 0);
    run_op(16'h0005, 16'h0009, 1'b0, 5, 0);
    run_op(16'h0F0F, 16'h00F1, 1'b1, 2, 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 0);

    // Reset mid-RUN at idx=2 must discard the operation.
    @(negedge clk);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; c_in = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check_val("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("midrst_sum", {16'b0, sum}, 32'd0);
    begin
      bit seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      check_val("midrst_no_result", {31'b0, seen}, 32'd0);
    end
    run_op(16'h1234, 16'h4321, 1'b0, 0, 0);

    for (int k = 0; k < 40; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
